adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one ripple-carry adder; one result in flight.
// Ports: clk, rst (async high), reqN_valid/a/b/ready, res_valid/sum/cout/id/ready.
// Macro ADDER_ARB_ROUND_ROBIN_EN: alternate grants on contention (else req0 wins).
module adder_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;
  logic             last_grant;

  logic             gnt_any;
  logic             gnt_id;
  logic             accept;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;

  assign gnt_any = req0_valid | req1_valid;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  // On contention pick whoever was not served last.
  assign gnt_id = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
`else
  assign gnt_id = ~req0_valid;

  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Readies are masked by rst so nothing looks accepted while held in reset.
  assign accept     = (state_q == IDLE) & ~rst & gnt_any;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;
  assign res_valid  = (state_q == HOLD);

  always_comb begin
    carry    = '0;
    sum_w    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_w[i]    = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1]  = (op_a[i] & op_b[i]) |
                    (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: state_d = HOLD;
      HOLD: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a       <= gnt_id ? req1_a : req0_a;
        op_b       <= gnt_id ? req1_b : req0_b;
        op_id      <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state_q == CALC) begin
        res_sum  <= sum_w;
        res_cout <= carry[WIDTH];
        res_id   <= op_id;
      end
    end
  end

endmodule
